// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared state encoding and default sizes for the register file
package reg_file_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 8;
  localparam int RF_NREAD = 2;
endpackage

// File: rtl/reg_file_clear_seq.sv
// reg_file_clear_seq: sweeps every array entry to zero after reset or on request
module reg_file_clear_seq import reg_file_pkg::*; #(
  parameter int DEPTH = RF_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          clearReq,
  output logic          busy,
  output logic          clrWe,
  output logic [AW-1:0] clrAddr
);
  clr_state_t state, nextState;
  logic [AW-1:0] clrPtr, nextPtr;
  always_ff @(posedge clk)
    if (!rstN) begin
      state <= CLEAR;
      clrPtr <= '0;
    end else begin
      state <= nextState;
      clrPtr <= nextPtr;
    end
  always_comb begin
    nextState = state == CLEAR ? (clrPtr == AW'(DEPTH - 1) ? IDLE : CLEAR) : (clearReq ? CLEAR : IDLE);
    nextPtr = state == CLEAR ? clrPtr + 1'b1 : '0;
  end
  always_comb begin
    busy = state == CLEAR;
    clrWe = state == CLEAR;
    clrAddr = clrPtr;
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with write bypass and clear engine
module reg_file_mp import reg_file_pkg::*; #(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int AW = $clog2(DEPTH),
  parameter int NREAD = RF_NREAD,
  parameter int ZERO_R0 = 0
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [NREAD*AW-1:0]    readSel,
  output logic [NREAD*WIDTH-1:0] readData,
  input  logic                   writeEn,
  input  logic [AW-1:0]          writeSel,
  input  logic [WIDTH-1:0]       writeData,
  input  logic                   clearReq,
  output logic                   busy,
  output logic                   writeDrop
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic clrWe, wrOk;
  logic [AW-1:0] clrAddr;
  reg_file_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr (
    .clk(clk),
    .rstN(rstN),
    .clearReq(clearReq),
    .busy(busy),
    .clrWe(clrWe),
    .clrAddr(clrAddr)
  );
  always_comb wrOk = rstN && writeEn && !busy && !clearReq && !(ZERO_R0 != 0 && writeSel == '0);
  always_ff @(posedge clk)
    if (rstN && clrWe) mem[clrAddr] <= '0;
    else if (wrOk) mem[writeSel] <= writeData;
  always_ff @(posedge clk)
    if (!rstN) writeDrop <= 1'b0;
    else writeDrop <= writeEn && (busy || clearReq);
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] sel;
    assign sel = readSel[k*AW +: AW];
    assign readData[k*WIDTH +: WIDTH] = busy ? '0 :
                                        (ZERO_R0 != 0 && sel == '0) ? '0 :
                                        (wrOk && sel == writeSel) ? writeData : mem[sel];
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: random and directed checks of two configurations against a reference model
module tb_reg_file_mp;
  localparam int D = 8;
  logic clk = 1'b0, rstN = 1'b0, writeEn = 1'b0, clearReq = 1'b0;
  logic [2:0] writeSel = '0;
  logic [15:0] writeData = '0;
  logic [2:0] rs [3];
  logic [5:0] readSelA;
  logic [8:0] readSelB;
  logic [31:0] readDataA;
  logic [47:0] readDataB;
  logic busyA, busyB, dropA, dropB;
  int vectors = 0, miscompares = 0;
  logic [15:0] mA [D], mB [D];
  int clrLeft = 0;
  logic dropExp = 1'b0;
  always #5 clk = ~clk;
  assign readSelA = {rs[1], rs[0]};
  assign readSelB = {rs[2], rs[1], rs[0]};
  reg_file_mp dutA (
    .clk(clk), .rstN(rstN), .readSel(readSelA), .readData(readDataA),
    .writeEn(writeEn), .writeSel(writeSel), .writeData(writeData),
    .clearReq(clearReq), .busy(busyA), .writeDrop(dropA)
  );
  reg_file_mp #(.NREAD(3), .ZERO_R0(1)) dutB (
    .clk(clk), .rstN(rstN), .readSel(readSelB), .readData(readDataB),
    .writeEn(writeEn), .writeSel(writeSel), .writeData(writeData),
    .clearReq(clearReq), .busy(busyB), .writeDrop(dropB)
  );
  function automatic logic [15:0] expRead(input bit zero, input logic [2:0] sel);
    if (clrLeft > 0) return 16'h0;
    if (zero && sel == 3'd0) return 16'h0;
    if (rstN && writeEn && !clearReq && !(zero && writeSel == 3'd0) && sel == writeSel) return writeData;
    return zero ? mB[sel] : mA[sel];
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    #1;
    check("busyA", 16'(busyA), 16'(clrLeft > 0));
    check("busyB", 16'(busyB), 16'(clrLeft > 0));
    check("dropA", 16'(dropA), 16'(dropExp));
    check("dropB", 16'(dropB), 16'(dropExp));
    for (int k = 0; k < 2; k++) check($sformatf("readA%0d", k), readDataA[k*16 +: 16], expRead(1'b0, rs[k]));
    for (int k = 0; k < 3; k++) check($sformatf("readB%0d", k), readDataB[k*16 +: 16], expRead(1'b1, rs[k]));
    @(posedge clk);
    if (!rstN) begin
      clrLeft = D;
      dropExp = 1'b0;
    end else if (clrLeft > 0) begin
      mA[D-clrLeft] = 16'h0;
      mB[D-clrLeft] = 16'h0;
      clrLeft--;
      dropExp = writeEn;
    end else if (clearReq) begin
      clrLeft = D;
      dropExp = writeEn;
    end else begin
      dropExp = 1'b0;
      if (writeEn) begin
        mA[writeSel] = writeData;
        if (writeSel != 3'd0) mB[writeSel] = writeData;
      end
    end
    @(negedge clk);
  endtask
  task automatic go(input logic we, input logic [2:0] ws, input logic [15:0] wd, input logic cr, input logic rn);
    writeEn = we;
    writeSel = ws;
    writeData = wd;
    clearReq = cr;
    rstN = rn;
    step();
  endtask
  task automatic setReads(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    rs[0] = a;
    rs[1] = b;
    rs[2] = c;
  endtask
  task automatic randReads();
    setReads(3'($urandom), 3'($urandom), 3'($urandom));
  endtask
  task automatic readAll();
    for (int i = 0; i < D; i++) begin
      setReads(3'(i), 3'(i), 3'(i));
      go(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    end
  endtask
  initial begin
    for (int i = 0; i < D; i++) begin
      mA[i] = 16'h0;
      mB[i] = 16'h0;
    end
    setReads(3'd0, 3'd1, 3'd2);
    @(posedge clk);
    clrLeft = D;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      randReads();
      go(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    end
    readAll();
    setReads(3'd3, 3'd2, 3'd3);
    go(1'b1, 3'd3, 16'h1234, 1'b0, 1'b1);
    go(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    setReads(3'd7, 3'd7, 3'd7);
    go(1'b1, 3'd7, 16'hA5A5, 1'b0, 1'b1);
    go(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    setReads(3'd0, 3'd0, 3'd0);
    go(1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b1);
    go(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    go(1'b1, 3'd1, 16'h1111, 1'b0, 1'b1);
    setReads(3'd1, 3'd5, 3'd1);
    go(1'b1, 3'd1, 16'h00FF, 1'b1, 1'b1);
    for (int i = 0; i < D; i++) go(1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1);
    go(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    readAll();
    for (int i = 0; i < D; i++) go(1'b1, 3'(i), 16'(16'h1000 + i), 1'b0, 1'b1);
    go(1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) go(1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    go(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      randReads();
      go(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    end
    readAll();
    for (int i = 0; i < 500; i++) begin
      randReads();
      go(1'($urandom), 3'($urandom), 16'($urandom), $urandom_range(19) == 0, $urandom_range(49) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the CPU datapath, replacing the fixed 8×16, two-read-port, edge-on-load register file. It has a clocked write port with read-after-write bypass, any number of read ports, and an optional hardwired-zero register 0. A sequential clear engine zeroes the array one entry per cycle after reset or on request, and raises `busy` while it runs.

## Interface
- `WIDTH`, 16: data width of each register.
- `DEPTH`, 8: number of registers. Must be a power of two, ≥2.
- `AW`, $clog2(DEPTH): select width. Derived; do not override.
- `NREAD`, 2: number of read ports, ≥1.
- `ZERO_R0`, 0: when 1, register 0 always reads 0 and writes to it are discarded.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rstN`, in, 1: synchronous, active-low reset.
- `readSel`, in, NREAD*AW: read selects. Port k uses bits [k*AW +: AW].
- `readData`, out, NREAD*WIDTH: read data. Port k uses bits [k*WIDTH +: WIDTH].
- `writeEn`, in, 1: write request for this cycle.
- `writeSel`, in, AW: destination register.
- `writeData`, in, WIDTH: data to write.
- `clearReq`, in, 1: request a full clear of the array.
- `busy`, out, 1: clear engine active. Writes are refused while high.
- `writeDrop`, out, 1: registered one-cycle pulse. Means the previous cycle's `writeEn` was refused.

## Operation
- **States:** IDLE and CLEAR, plus a pointer `clrPtr` (AW bits).
- **Reset:** the clock edge with `rstN`=0 sets state CLEAR, `clrPtr`=0, `busy`=1, `writeDrop`=0. The array itself is not touched by reset.
- **CLEAR:** on each edge with `rstN`=1:
  - writes `array[clrPtr] <= 0`, then increments `clrPtr`;
  - on the edge that clears entry DEPTH-1, moves to IDLE and `clrPtr` wraps to 0.
- **IDLE:**
  - `clearReq`=1 moves to CLEAR on the next edge with `clrPtr`=0.
  - Otherwise `writeEn`=1 writes `array[writeSel] <= writeData`.
- **Write refused:** when `writeEn`=1 and any of the following holds:
  - state is CLEAR;
  - `clearReq`=1 in the same cycle (clear wins over write);
  - `ZERO_R0`=1 and `writeSel`=0.
  - Then no array write happens and `writeDrop`=1 on the next cycle. The `ZERO_R0` case drops silently and does not pulse `writeDrop`.
- **`clearReq` during CLEAR:** ignored. The sweep does not restart.
- **Reset mid-CLEAR:** pointer returns to 0 and the full sweep restarts.
- **Reads:** combinational and independent per port. Evaluated in priority order:
  1. `busy`=1 → 0.
  2. `ZERO_R0`=1 and sel=0 → 0.
  3. Sel equals `writeSel`, and a write to it is accepted this cycle → `writeData` (bypass).
  4. Otherwise → `array[sel]`.
- **Duplicate selects:** several ports may select the same register. All return identical data.

## Timing
- **Write-to-read latency:** 0 cycles through the bypass, 1 cycle through the array.
- **After reset release:** `busy` stays high for exactly DEPTH rising edges, then drops. The first accepted write is on edge DEPTH+1 after release.
- **After `clearReq`:** accepted in IDLE at edge N, `busy` is high from after edge N through edge N+DEPTH.
- **`writeDrop`:** asserts in the cycle after the refused request and lasts 1 cycle per refused request.
- **No combinational path** from `clearReq` to `busy`. `busy` is a registered state decode.

## Structure
- Package `reg_file_pkg`:
  - state enum `clr_state_t` {IDLE, CLEAR};
  - default constants `RF_WIDTH`=16, `RF_DEPTH`=8, `RF_NREAD`=2.
- Sub-module `reg_file_clear_seq`: IDLE/CLEAR FSM plus `clrPtr`. Outputs `busy`, `clrWe`, `clrAddr`.
- Top level holds the array, write arbitration, `writeDrop` register and the generate loop of read muxes with bypass.

## Test plan
- **Reset then clear:** pulse `rstN` low 1 cycle → `busy`=1 for 8 cycles, then 0. Afterwards all 8 registers read 0 on both ports.
- **Write then read:** with `busy`=0, write r3=0x1234 → the same-cycle read of r3 returns 0x1234 via bypass, and the next cycle returns 0x1234 from the array. r2 is unchanged.
- **Write during CLEAR:** `writeEn` to r5=0xBEEF while `busy` → `writeDrop`=1 next cycle, and r5 reads 0 after the clear.
- **Simultaneous clear and write:** `clearReq` and `writeEn`(r1=0x00FF) in the same cycle → write dropped, `writeDrop` pulses, and after 8 busy cycles r1=0.
- **Zero register:** with `ZERO_R0`=1, write r0=0xFFFF → r0 reads 0 and `writeDrop`=0. With NREAD=3, all three ports selecting r7=0xA5A5 → all return 0xA5A5.
- **Reset mid-clear:** assert `rstN` low at the 4th CLEAR cycle → after release `busy` lasts a full 8 cycles, and all entries are zero.
